// File: rtl/jzjpcc_hazard_pkg.sv
// rtl/jzjpcc_hazard_pkg.sv - shared types for the jzjpcc hazard controller
package jzjpcc_hazard_pkg;

    typedef enum logic [1:0] {
        RESET_FLUSH = 2'd0,
        RUN         = 2'd1,
        LOAD_STALL  = 2'd2
    } hazard_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_EX  = 2'd1;
    localparam fwd_sel_t FWD_MEM = 2'd2;
    localparam fwd_sel_t FWD_WB  = 2'd3;

endpackage

// File: rtl/jzjpcc_forward_select.sv
// rtl/jzjpcc_forward_select.sv - bypass select and load-hazard flag for one decode source
module jzjpcc_forward_select
    import jzjpcc_hazard_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic [4:0] srcAddr,
    input  logic       srcUsed,
    input  logic [4:0] rdAddr_execute,
    input  logic [4:0] rdAddr_memory,
    input  logic [4:0] rdAddr_writeback,
    input  logic       rdWriteEnable_execute,
    input  logic       rdWriteEnable_memory,
    input  logic       rdWriteEnable_writeback,
    input  logic       rdSource_execute,
    input  logic       rdSource_memory,
    output logic [1:0] forwardSelect,
    output logic       loadHazard
);

    logic src_valid;
    logic match_ex;
    logic match_mem;
    logic match_wb;

    assign src_valid = srcUsed && (srcAddr != 5'd0);
    assign match_ex  = src_valid && rdWriteEnable_execute   && (rdAddr_execute   == srcAddr);
    assign match_mem = src_valid && rdWriteEnable_memory    && (rdAddr_memory    == srcAddr);
    assign match_wb  = src_valid && rdWriteEnable_writeback && (rdAddr_writeback == srcAddr);

    assign loadHazard = match_ex && rdSource_execute;

    // A load still in execute has no data yet, so it yields to older stages.
    always_comb begin
        forwardSelect = FWD_RF;
        if (match_ex && !rdSource_execute) begin
            forwardSelect = FWD_EX;
        end else if (match_mem && !((LOAD_USE_BUBBLES == 2) && rdSource_memory)) begin
            forwardSelect = FWD_MEM;
        end else if (match_wb) begin
            forwardSelect = FWD_WB;
        end
    end

endmodule

// File: rtl/jzjpcc_hazard_controller.sv
// rtl/jzjpcc_hazard_controller.sv - forwarding, load-use bubbles, control-transfer flushes, event counters
module jzjpcc_hazard_controller
    import jzjpcc_hazard_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int COUNTER_WIDTH    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4:0]               rs1Addr_decode,
    input  logic [4:0]               rs2Addr_decode,
    input  logic                     rs1Used_decode,
    input  logic                     rs2Used_decode,
    input  logic [4:0]               rdAddr_execute,
    input  logic [4:0]               rdAddr_memory,
    input  logic [4:0]               rdAddr_writeback,
    input  logic                     rdWriteEnable_execute,
    input  logic                     rdWriteEnable_memory,
    input  logic                     rdWriteEnable_writeback,
    input  logic                     rdSource_execute,
    input  logic                     rdSource_memory,
    input  logic                     pcCTWriteEnable,
    output logic                     stall_fetch,
    output logic                     stall_decode,
    output logic                     flush_decode,
    output logic                     flush_execute,
    output logic [1:0]               rs1Forward_decode,
    output logic [1:0]               rs2Forward_decode,
    output logic [COUNTER_WIDTH-1:0] stallCount,
    output logic [COUNTER_WIDTH-1:0] flushCount
);

    hazard_state_t            state_q, state_d;
    logic [1:0]               bubble_q, bubble_d;
    logic [COUNTER_WIDTH-1:0] stall_count_q, flush_count_q;

    logic [1:0] rs1_sel, rs2_sel;
    logic       rs1_load_hazard, rs2_load_hazard;
    logic       load_use;

    jzjpcc_forward_select #(.LOAD_USE_BUBBLES(LOAD_USE_BUBBLES)) u_rs1_select (
        .srcAddr                (rs1Addr_decode),
        .srcUsed                (rs1Used_decode),
        .rdAddr_execute         (rdAddr_execute),
        .rdAddr_memory          (rdAddr_memory),
        .rdAddr_writeback       (rdAddr_writeback),
        .rdWriteEnable_execute  (rdWriteEnable_execute),
        .rdWriteEnable_memory   (rdWriteEnable_memory),
        .rdWriteEnable_writeback(rdWriteEnable_writeback),
        .rdSource_execute       (rdSource_execute),
        .rdSource_memory        (rdSource_memory),
        .forwardSelect          (rs1_sel),
        .loadHazard             (rs1_load_hazard)
    );

    jzjpcc_forward_select #(.LOAD_USE_BUBBLES(LOAD_USE_BUBBLES)) u_rs2_select (
        .srcAddr                (rs2Addr_decode),
        .srcUsed                (rs2Used_decode),
        .rdAddr_execute         (rdAddr_execute),
        .rdAddr_memory          (rdAddr_memory),
        .rdAddr_writeback       (rdAddr_writeback),
        .rdWriteEnable_execute  (rdWriteEnable_execute),
        .rdWriteEnable_memory   (rdWriteEnable_memory),
        .rdWriteEnable_writeback(rdWriteEnable_writeback),
        .rdSource_execute       (rdSource_execute),
        .rdSource_memory        (rdSource_memory),
        .forwardSelect          (rs2_sel),
        .loadHazard             (rs2_load_hazard)
    );

    assign load_use = rs1_load_hazard || rs2_load_hazard;

    // Control transfers beat load-use: the instruction being held is wrong-path.
    always_comb begin
        stall_fetch       = 1'b0;
        stall_decode      = 1'b0;
        flush_decode      = 1'b0;
        flush_execute     = 1'b0;
        rs1Forward_decode = rs1_sel;
        rs2Forward_decode = rs2_sel;
        state_d           = state_q;
        bubble_d          = bubble_q;
        case (state_q)
            RESET_FLUSH: begin
                flush_decode      = 1'b1;
                flush_execute     = 1'b1;
                rs1Forward_decode = FWD_RF;
                rs2Forward_decode = FWD_RF;
                state_d           = RUN;
                bubble_d          = 2'd0;
            end
            RUN: begin
                if (pcCTWriteEnable) begin
                    flush_decode  = 1'b1;
                    flush_execute = 1'b1;
                end else if (load_use) begin
                    stall_fetch   = 1'b1;
                    stall_decode  = 1'b1;
                    flush_execute = 1'b1;
                    if (LOAD_USE_BUBBLES > 1) begin
                        state_d  = LOAD_STALL;
                        bubble_d = 2'(LOAD_USE_BUBBLES - 1);
                    end
                end
            end
            LOAD_STALL: begin
                if (pcCTWriteEnable) begin
                    flush_decode  = 1'b1;
                    flush_execute = 1'b1;
                    state_d       = RUN;
                    bubble_d      = 2'd0;
                end else begin
                    stall_fetch   = 1'b1;
                    stall_decode  = 1'b1;
                    flush_execute = 1'b1;
                    bubble_d      = bubble_q - 2'd1;
                    if (bubble_q <= 2'd1) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d  = RESET_FLUSH;
                bubble_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RESET_FLUSH;
            bubble_q      <= 2'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
            if (stall_decode && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + COUNTER_WIDTH'(1);
            end
            if (pcCTWriteEnable && (state_q != RESET_FLUSH) && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + COUNTER_WIDTH'(1);
            end
        end
    end

    assign stallCount = stall_count_q;
    assign flushCount = flush_count_q;

endmodule

// File: tb/tb_jzjpcc_hazard_controller.sv
// tb/tb_jzjpcc_hazard_controller.sv - randomized and directed bench for jzjpcc_hazard_controller
module tb_jzjpcc_hazard_controller;

    localparam int N = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [4:0] rs1, rs2, rd_ex, rd_mem, rd_wb;
    logic       u1, u2, we_ex, we_mem, we_wb, src_ex, src_mem, ct;

    logic        sf [N];
    logic        sd [N];
    logic        fd [N];
    logic        fe [N];
    logic [1:0]  f1 [N];
    logic [1:0]  f2 [N];
    logic [31:0] sc_w [2];
    logic [31:0] fc_w [2];
    logic [3:0]  sc_s, fc_s;

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0: one bubble; 1: two bubbles; 2: one bubble with 4-bit counters.
    jzjpcc_hazard_controller #(.LOAD_USE_BUBBLES(1), .COUNTER_WIDTH(32)) dut0 (
        .clock(clock), .reset(reset),
        .rs1Addr_decode(rs1), .rs2Addr_decode(rs2),
        .rs1Used_decode(u1), .rs2Used_decode(u2),
        .rdAddr_execute(rd_ex), .rdAddr_memory(rd_mem), .rdAddr_writeback(rd_wb),
        .rdWriteEnable_execute(we_ex), .rdWriteEnable_memory(we_mem),
        .rdWriteEnable_writeback(we_wb),
        .rdSource_execute(src_ex), .rdSource_memory(src_mem),
        .pcCTWriteEnable(ct),
        .stall_fetch(sf[0]), .stall_decode(sd[0]),
        .flush_decode(fd[0]), .flush_execute(fe[0]),
        .rs1Forward_decode(f1[0]), .rs2Forward_decode(f2[0]),
        .stallCount(sc_w[0]), .flushCount(fc_w[0])
    );

    jzjpcc_hazard_controller #(.LOAD_USE_BUBBLES(2), .COUNTER_WIDTH(32)) dut1 (
        .clock(clock), .reset(reset),
        .rs1Addr_decode(rs1), .rs2Addr_decode(rs2),
        .rs1Used_decode(u1), .rs2Used_decode(u2),
        .rdAddr_execute(rd_ex), .rdAddr_memory(rd_mem), .rdAddr_writeback(rd_wb),
        .rdWriteEnable_execute(we_ex), .rdWriteEnable_memory(we_mem),
        .rdWriteEnable_writeback(we_wb),
        .rdSource_execute(src_ex), .rdSource_memory(src_mem),
        .pcCTWriteEnable(ct),
        .stall_fetch(sf[1]), .stall_decode(sd[1]),
        .flush_decode(fd[1]), .flush_execute(fe[1]),
        .rs1Forward_decode(f1[1]), .rs2Forward_decode(f2[1]),
        .stallCount(sc_w[1]), .flushCount(fc_w[1])
    );

    jzjpcc_hazard_controller #(.LOAD_USE_BUBBLES(1), .COUNTER_WIDTH(4)) dut2 (
        .clock(clock), .reset(reset),
        .rs1Addr_decode(rs1), .rs2Addr_decode(rs2),
        .rs1Used_decode(u1), .rs2Used_decode(u2),
        .rdAddr_execute(rd_ex), .rdAddr_memory(rd_mem), .rdAddr_writeback(rd_wb),
        .rdWriteEnable_execute(we_ex), .rdWriteEnable_memory(we_mem),
        .rdWriteEnable_writeback(we_wb),
        .rdSource_execute(src_ex), .rdSource_memory(src_mem),
        .pcCTWriteEnable(ct),
        .stall_fetch(sf[2]), .stall_decode(sd[2]),
        .flush_decode(fd[2]), .flush_execute(fe[2]),
        .rs1Forward_decode(f1[2]), .rs2Forward_decode(f2[2]),
        .stallCount(sc_s), .flushCount(fc_s)
    );

    // Reference model: pending bubble count, reset-flush flag, plain integer counters.
    int              lub  [N] = '{1, 2, 1};
    longint unsigned mmax [N] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    bit              mrf  [N];
    int              mpend[N];
    longint unsigned msc  [N];
    longint unsigned mfc  [N];
    bit              mstall[N];

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fwd(int l, logic [4:0] a, logic u);
        if (!u || a == 0) return 0;
        if (we_ex && rd_ex == a && !src_ex) return 1;
        if (we_mem && rd_mem == a && !(l == 2 && src_mem)) return 2;
        if (we_wb && rd_wb == a) return 3;
        return 0;
    endfunction

    function automatic bit hazard();
        return (u1 && rs1 != 0 && we_ex && src_ex && rd_ex == rs1) ||
               (u2 && rs2 != 0 && we_ex && src_ex && rd_ex == rs2);
    endfunction

    function automatic longint unsigned sc_of(int k);
        return (k == 2) ? longint'(sc_s) : longint'(sc_w[k]);
    endfunction

    function automatic longint unsigned fc_of(int k);
        return (k == 2) ? longint'(fc_s) : longint'(fc_w[k]);
    endfunction

    task automatic clr();
        {rs1, rs2, rd_ex, rd_mem, rd_wb} = '0;
        {u1, u2, we_ex, we_mem, we_wb, src_ex, src_mem, ct} = '0;
        reset = 1'b0;
    endtask

    task automatic settle_check();
        int esf, efd, efe, ef1, ef2;
        #4;
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                mrf[k] = 1; mpend[k] = 0; msc[k] = 0; mfc[k] = 0;
            end
            esf = 0; efd = 0; efe = 0; ef1 = 0; ef2 = 0;
            if (mrf[k]) begin
                efd = 1; efe = 1;
            end else begin
                ef1 = fwd(lub[k], rs1, u1);
                ef2 = fwd(lub[k], rs2, u2);
                if (ct) begin
                    efd = 1; efe = 1;
                end else if (mpend[k] > 0 || hazard()) begin
                    esf = 1; efe = 1;
                end
            end
            mstall[k] = (esf == 1);
            check($sformatf("d%0d.stall_fetch", k),   sf[k], esf);
            check($sformatf("d%0d.stall_decode", k),  sd[k], esf);
            check($sformatf("d%0d.flush_decode", k),  fd[k], efd);
            check($sformatf("d%0d.flush_execute", k), fe[k], efe);
            check($sformatf("d%0d.rs1Forward", k),    f1[k], ef1);
            check($sformatf("d%0d.rs2Forward", k),    f2[k], ef2);
            check($sformatf("d%0d.stallCount", k),    sc_of(k), msc[k]);
            check($sformatf("d%0d.flushCount", k),    fc_of(k), mfc[k]);
        end
    endtask

    task automatic advance();
        for (int k = 0; k < N; k++) begin
            if (!reset) begin
                if (mrf[k]) begin
                    mrf[k] = 0;
                end else begin
                    if (ct) begin
                        mpend[k] = 0;
                        if (mfc[k] < mmax[k]) mfc[k]++;
                    end else if (mpend[k] > 0) begin
                        mpend[k]--;
                    end else if (hazard()) begin
                        mpend[k] = lub[k] - 1;
                    end
                    if (mstall[k] && msc[k] < mmax[k]) msc[k]++;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clr(); reset = 1'b1;
        settle_check(); advance();
        reset = 1'b0;
        settle_check(); advance();
    endtask

    task automatic load_use_x7();
        clr(); we_ex = 1; rd_ex = 7; src_ex = 1; rs2 = 7; u2 = 1;
    endtask

    initial begin
        // Reset held, then exactly one flush cycle after release, then quiet RUN.
        clr(); reset = 1'b1;
        settle_check();
        check("rst.flush_decode", fd[0], 1);
        advance();
        reset = 1'b0;
        settle_check();
        check("rel.flush_execute", fe[1], 1);
        advance();
        settle_check();
        check("run.flush_decode", fd[0], 0);
        check("run.stall_decode", sd[1], 0);
        advance();

        // ALU result forwarding, and x0 never matching.
        clr(); we_ex = 1; rd_ex = 5; rs1 = 5; u1 = 1;
        settle_check();
        check("alu.rs1Forward", f1[0], 1);
        check("alu.stall", sd[0], 0);
        advance();
        rd_ex = 0; rs1 = 0;
        settle_check();
        check("x0.rs1Forward", f1[0], 0);
        advance();

        // Load-use on x7: one bubble vs two bubbles.
        do_reset();
        load_use_x7();
        settle_check();
        check("lu.stall1", sd[0], 1);
        check("lu.stall2", sd[1], 1);
        advance();
        clr(); we_mem = 1; rd_mem = 7; src_mem = 1; rs2 = 7; u2 = 1;
        settle_check();
        check("lu1.rs2Forward", f2[0], 2);
        check("lu1.stallCount", sc_w[0], 1);
        check("lu2.still_stalled", sd[1], 1);
        advance();
        clr(); we_wb = 1; rd_wb = 7; rs2 = 7; u2 = 1;
        settle_check();
        check("lu2.rs2Forward", f2[1], 3);
        check("lu2.stall_done", sd[1], 0);
        check("lu2.stallCount", sc_w[1], 2);
        advance();

        // Control transfer colliding with load-use.
        do_reset();
        load_use_x7(); ct = 1;
        settle_check();
        check("ct.flush_decode", fd[0], 1);
        check("ct.flush_execute", fe[0], 1);
        check("ct.stall_fetch", sf[0], 0);
        advance();
        clr();
        settle_check();
        check("ct.flushCount", fc_w[0], 1);
        check("ct.stallCount", sc_w[0], 0);
        advance();

        // Control transfer aborting LOAD_STALL.
        do_reset();
        load_use_x7();
        settle_check(); advance();
        clr(); ct = 1;
        settle_check();
        check("abort.stall", sd[1], 0);
        check("abort.flush_decode", fd[1], 1);
        advance();
        clr();
        settle_check();
        check("abort.run", sd[1], 0);
        advance();

        // Reset pulse in the middle of LOAD_STALL.
        do_reset();
        load_use_x7();
        settle_check(); advance();
        reset = 1'b1;
        settle_check();
        check("rls.stallCount", sc_w[1], 0);
        check("rls.flush_decode", fd[1], 1);
        check("rls.flush_execute", fe[1], 1);
        advance();
        clr();
        settle_check();
        check("rls.one_flush", fd[1], 1);
        advance();
        settle_check();
        check("rls.run_flush", fe[1], 0);
        check("rls.run_stall", sf[1], 0);
        advance();

        // Twenty stall cycles saturate the 4-bit counter.
        do_reset();
        load_use_x7();
        repeat (20) begin
            settle_check(); advance();
        end
        settle_check();
        check("sat.stallCount4", sc_s, 15);
        check("sat.stallCount32", sc_w[0], 20);
        advance();

        // Randomized traffic with small address space for frequent matches.
        for (int i = 0; i < 3000; i++) begin
            rs1     = 5'($urandom_range(0, 3));
            rs2     = 5'($urandom_range(0, 3));
            rd_ex   = 5'($urandom_range(0, 3));
            rd_mem  = 5'($urandom_range(0, 3));
            rd_wb   = 5'($urandom_range(0, 3));
            u1      = 1'($urandom);
            u2      = 1'($urandom);
            we_ex   = 1'($urandom);
            we_mem  = 1'($urandom);
            we_wb   = 1'($urandom);
            src_ex  = 1'($urandom);
            src_mem = 1'($urandom);
            ct      = ($urandom_range(0, 7) == 0);
            reset   = ($urandom_range(0, 99) == 0);
            settle_check();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
